// File: rtl/hazard_unit_pkg.sv
// hazard_unit_pkg: forwarding select codes and pipeline stage record types
package hazard_unit_pkg;
    localparam int REG_AW = 5;
    localparam logic [1:0] FWD_SEL_RF  = 2'b00;
    localparam logic [1:0] FWD_SEL_WB  = 2'b01;
    localparam logic [1:0] FWD_SEL_MEM = 2'b10;
    typedef struct packed {
        logic              valid;
        logic [REG_AW-1:0] rd;
        logic              we;
        logic              mem_rd;
    } stage_rec_t;
    typedef struct packed {
        logic              valid;
        logic [REG_AW-1:0] rd;
        logic              we;
        logic              mem_rd;
        logic [REG_AW-1:0] rs1;
        logic [REG_AW-1:0] rs2;
    } ex_rec_t;
    function automatic logic qualifies(input stage_rec_t r);
        return r.valid && r.we && (r.rd != '0);
    endfunction
endpackage

// File: rtl/hazard_unit_fwd_sel.sv
// fwd_sel: picks the youngest qualifying producer (MEM over WB) for one EX operand
module fwd_sel
    import hazard_unit_pkg::*;
(
    input  stage_rec_t        mem_rec,
    input  stage_rec_t        wb_rec,
    input  logic [REG_AW-1:0] rs,
    output logic [1:0]        sel
);
    always_comb begin
        sel = (qualifies(mem_rec) && mem_rec.rd == rs) ? FWD_SEL_MEM :
              (qualifies(wb_rec) && wb_rec.rd == rs)   ? FWD_SEL_WB  : FWD_SEL_RF;
    end
endmodule

// File: rtl/hazard_unit.sv
// hazard_unit: shadow EX/MEM/WB records driving forwarding selects, load-use stalls and branch flushes
module hazard_unit
    import hazard_unit_pkg::*;
(
    input  logic              clk,
    input  logic              rst_n,
    input  logic [REG_AW-1:0] id_rs1_addr,
    input  logic [REG_AW-1:0] id_rs2_addr,
    input  logic              id_rs1_used,
    input  logic              id_rs2_used,
    input  logic [REG_AW-1:0] id_rd_addr,
    input  logic              id_reg_we,
    input  logic              id_mem_rd,
    input  logic              ex_branch_taken,
    output logic [1:0]        fwd_a_sel,
    output logic [1:0]        fwd_b_sel,
    output logic              stall_if,
    output logic              stall_id,
    output logic              flush_id,
    output logic              flush_ex
);
    ex_rec_t    ex_q, ex_d;
    stage_rec_t mem_q, mem_d, wb_q, wb_d;
    logic [1:0] sel_a, sel_b;
    logic       load_use;

    fwd_sel u_fwd_a (.mem_rec(mem_q), .wb_rec(wb_q), .rs(ex_q.rs1), .sel(sel_a));
    fwd_sel u_fwd_b (.mem_rec(mem_q), .wb_rec(wb_q), .rs(ex_q.rs2), .sel(sel_b));

    // A taken branch discards the stalled consumer, so it overrides load-use
    always_comb begin
        load_use  = ex_q.valid && ex_q.mem_rd && (ex_q.rd != '0) &&
                    ((id_rs1_used && ex_q.rd == id_rs1_addr) ||
                     (id_rs2_used && ex_q.rd == id_rs2_addr));
        fwd_a_sel = rst_n ? sel_a : FWD_SEL_RF;
        fwd_b_sel = rst_n ? sel_b : FWD_SEL_RF;
        stall_if  = rst_n && load_use && !ex_branch_taken;
        stall_id  = stall_if;
        flush_id  = rst_n && ex_branch_taken;
        flush_ex  = rst_n && (ex_branch_taken || load_use);
        ex_d      = flush_ex ? '0 : '{valid: 1'b1, rd: id_rd_addr, we: id_reg_we,
                                      mem_rd: id_mem_rd, rs1: id_rs1_addr, rs2: id_rs2_addr};
        mem_d     = '{valid: ex_q.valid, rd: ex_q.rd, we: ex_q.we, mem_rd: ex_q.mem_rd};
        wb_d      = mem_q;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            ex_q  <= '0;
            mem_q <= '0;
            wb_q  <= '0;
        end else begin
            ex_q  <= ex_d;
            mem_q <= mem_d;
            wb_q  <= wb_d;
        end
    end
endmodule

// File: doc/hazard_unit.md
# hazard_unit

Pipeline hazard and forwarding controller for the 5-stage RISC-V core. It produces the 2-bit select codes consumed by the two operand `mux3` instances in EX, and the stall and flush controls for IF/ID/EX. It tracks the destination registers of the in-flight EX, MEM and WB instructions in internal shadow registers. From these it detects RAW hazards, chooses the forwarding source, inserts load-use bubbles and squashes wrong-path instructions on a taken branch.

## Interface
- `REG_AW`, 5: register address width.
- `clk` in 1: core clock. All state updates on the rising edge.
- `rst_n` in 1: synchronous reset, active low.
- `id_rs1_addr`, `id_rs2_addr` in REG_AW: source registers of the instruction in ID.
- `id_rs1_used`, `id_rs2_used` in 1: the source is actually read (not U/J-type, not an immediate slot).
- `id_rd_addr` in REG_AW: destination of the ID instruction.
- `id_reg_we` in 1: the ID instruction writes the regfile.
- `id_mem_rd` in 1: the ID instruction is a load.
- `ex_branch_taken` in 1: the branch or jump resolved in EX redirects the PC this cycle.
- `fwd_a_sel`, `fwd_b_sel` out 2: operand mux selects for EX.
  - 2'b00: regfile/ID-EX value.
  - 2'b01: WB result.
  - 2'b10: MEM ALU result.
  - 2'b11 is never driven.
- `stall_if`, `stall_id` out 1: hold the PC and the IF/ID register.
- `flush_id` out 1: clear the IF/ID register.
- `flush_ex` out 1: load a bubble into the ID/EX register.

## Operation
- Shadow records for EX, MEM and WB, each holding {valid, rd, we, mem_rd}. The EX record also holds rs1 and rs2.
- A record qualifies for forwarding only when valid && we && rd != 0.
- Advance on every clock edge: WB <= MEM, MEM <= EX, and EX <= the ID fields.
  - If `flush_ex` is 1, EX instead becomes a bubble (valid=0).
- `fwd_a_sel`, evaluated against EX.rs1; `fwd_b_sel` is identical, using EX.rs2:
  - 2'b10 if MEM qualifies and MEM.rd == EX.rs1.
  - Else 2'b01 if WB qualifies and WB.rd == EX.rs1.
  - Else 2'b00.
  - MEM has priority over WB, so the youngest producer wins.
- Load-use hazard:
  - Condition: EX is valid, EX.mem_rd = 1, EX.rd != 0, and EX.rd matches an ID source that is in use.
  - Response: `stall_if` = `stall_id` = `flush_ex` = 1 for exactly one cycle. Afterwards the load is in MEM, and the consumer reaches EX when the load reaches WB, so the 2'b01 path is used.
- A load in MEM never feeds EX through the 2'b10 path; the load-use bubble guarantees this.
- Taken branch:
  - `flush_id` = `flush_ex` = 1; `stall_if` = `stall_id` = 0.
  - Branch overrides load-use: the stalled consumer is wrong-path and is discarded.
- A WB-to-ID same-cycle read is not this block's concern. The regfile is write-first.
- `rd` = x0 never forwards and never stalls.

## Timing
- `fwd_*_sel`, `stall_*` and `flush_*` are combinational from the shadow records and the ID/branch inputs. Zero latency: they are valid in the same cycle.
- Shadow records update one cycle after the ID inputs are sampled.
- A load-use stall lasts exactly 1 cycle. It never repeats for the same pair, because the next cycle EX holds a bubble.
- Reset:
  - While `rst_n` = 0, all records are cleared on the edge.
  - All outputs are forced to 0 (sel = 2'b00, no stall, no flush).
- Reset asserted mid-stall or mid-flush: the state is cleared on the next edge, and no residual stall is issued after release.
- Simultaneous branch and load-use in the same cycle: branch wins (flush_id = flush_ex = 1, stall = 0).
- Back-to-back writers of the same rd in MEM and WB: MEM is selected (2'b10).

## Structure
- Shared include, alongside the core defines:
  - `FWD_SEL_RF` = 2'b00
  - `FWD_SEL_WB` = 2'b01
  - `FWD_SEL_MEM` = 2'b10
  - the stage-record field widths
- Sub-module `fwd_sel`: combinational source comparator against the MEM and WB records. Instantiated twice, for operands A and B.
- The top level holds the shadow-record registers and the stall/flush logic.

## Test plan
- ALU dependency at distance 1: `add x5,..` then `sub x6,x5,x1` gives `fwd_a_sel` = 2'b10 in the sub's EX cycle, with no stall.
- ALU dependency at distance 2: x5 produced, one independent instruction, then a consumer in rs2 gives `fwd_b_sel` = 2'b01.
- Double producer: two writes to x7 in sequence, then a read of x7 gives 2'b10, not 2'b01.
- Load-use: `lw x3` followed by `add x4,x3,x3`:
  - stall_if = stall_id = flush_ex = 1 for one cycle;
  - then both selects are 2'b01 when the add is in EX.
- x0 and unused sources:
  - a writer to x0 followed by a reader of x0 gives sel 00;
  - a load to x9 followed by a U-type instruction (`id_rs1_used` = 0) with rs1 field 9 gives no stall.
- Branch during load-use: `ex_branch_taken` = 1 in the hazard cycle gives flush_id = flush_ex = 1 and stall = 0. Assert `rst_n` = 0 mid-sequence and check that all outputs are 0 the following cycle.
